// File: rtl/accel_pkg.sv
// Shared opcodes, sequencer state encoding and instruction field helpers
// for the accelerator sequencer slice.
package accel_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_SETBASE = 4'h1;
  localparam logic [3:0] OP_SETLANE = 4'h2;
  localparam logic [3:0] OP_CALC    = 4'h3;
  localparam logic [3:0] OP_LOOP    = 4'h4;
  localparam logic [3:0] OP_ENDLOOP = 4'h5;
  localparam logic [3:0] OP_HALT    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE,
    S_ERROR
  } seq_state_t;

  function automatic logic [3:0] instr_op(input logic [15:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic [11:0] instr_imm(input logic [15:0] instr);
    return instr[11:0];
  endfunction

endpackage

// File: rtl/accel_addr_gen.sv
// Operand address generator: holds the base register and the CALC beat
// counter, producing the beat address, last-beat flag and accept strobe.
module accel_addr_gen #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_base_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] count_i,
  input  logic                  active_i,
  input  logic                  ready_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o,
  output logic                  beat_o
);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      cnt_q  <= '0;
      n_q    <= '0;
    end else begin
      if (set_base_i) base_q <= base_i;
      if (load_i) begin
        cnt_q <= '0;
        n_q   <= count_i;
      end else if (beat_o && !last_o) begin
        cnt_q <= cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Address wraps naturally modulo 2**ADDR_WIDTH.
  assign addr_o = base_q + cnt_q;
  assign last_o = active_i && (cnt_q == n_q - ADDR_WIDTH'(1));
  assign beat_o = active_i && ready_i;

endmodule

// File: rtl/accel_sequencer.sv
// Programmable sequencer: fetches 16-bit instructions from a sync ROM and
// drives CALC beats into the PE array, with one-level loops and a trap.
module accel_sequencer
  import accel_pkg::*;
#(
  parameter int PC_WIDTH   = 6,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_LANES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [15:0]           instruction,
  output logic                  pe_valid,
  input  logic                  pe_ready,
  output logic [ADDR_WIDTH-1:0] pe_addr,
  output logic                  pe_last,
  output logic [NUM_LANES-1:0]  pe_lane_en,
  output seq_state_t            dbg_state_o
);

  // PE handshake: a beat transfers on any rising edge where pe_valid and
  // pe_ready are both high; pe_valid and the beat payload are held stable
  // while pe_ready is low, and pe_valid never depends on pe_ready.

  seq_state_t            state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic                  valid_q;
  logic [NUM_LANES-1:0]  mask_q;
  logic                  loop_active_q;
  logic [PC_WIDTH-1:0]   loop_pc_q;
  logic [7:0]            loop_cnt_q;

  logic [3:0]            op;
  logic [11:0]           imm;
  logic [ADDR_WIDTH-1:0] imm_aw;
  logic [NUM_LANES-1:0]  imm_nl;
  logic [7:0]            imm_k;
  logic                  unused_imm;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic                  in_decode;
  logic                  endloop_taken;
  logic                  beat;
  logic                  last;

  assign op         = instr_op(instruction);
  assign imm        = instr_imm(instruction);
  assign imm_aw     = imm[ADDR_WIDTH-1:0];
  assign imm_nl     = imm[NUM_LANES-1:0];
  assign imm_k      = imm[7:0];
  assign unused_imm = ^imm;
  assign pc_inc     = pc_q + PC_WIDTH'(1);
  assign in_decode  = (state_q == S_DECODE);
  assign endloop_taken = loop_active_q && (loop_cnt_q != 8'd0);

  accel_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_base_i(in_decode && (op == OP_SETBASE)),
    .base_i    (imm_aw),
    .load_i    (in_decode && (op == OP_CALC)),
    .count_i   (imm_aw),
    .active_i  (valid_q),
    .ready_i   (pe_ready),
    .addr_o    (pe_addr),
    .last_o    (last),
    .beat_o    (beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      valid_q       <= 1'b0;
      mask_q        <= '1;
      loop_active_q <= 1'b0;
      loop_pc_q     <= '0;
      loop_cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q       <= S_FETCH;
            pc_q          <= '0;
            busy_q        <= 1'b1;
            error_q       <= 1'b0;
            loop_active_q <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          // Default path: next instruction; specific opcodes override below.
          state_q <= S_FETCH;
          pc_q    <= pc_inc;
          case (op)
            OP_NOP, OP_SETBASE: ;
            OP_SETLANE: mask_q <= imm_nl;
            OP_CALC: begin
              if (imm_aw != '0) begin
                state_q <= S_EXEC;
                valid_q <= 1'b1;
              end
            end
            OP_LOOP: begin
              loop_active_q <= 1'b1;
              loop_pc_q     <= pc_inc;
              loop_cnt_q    <= (imm_k == 8'd0) ? 8'd0 : imm_k - 8'd1;
            end
            OP_ENDLOOP: begin
              if (endloop_taken) begin
                pc_q       <= loop_pc_q;
                loop_cnt_q <= loop_cnt_q - 8'd1;
              end else begin
                loop_active_q <= 1'b0;
              end
            end
            OP_HALT: begin
              state_q <= S_DONE;
              pc_q    <= pc_q;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            default: begin
              state_q <= S_ERROR;
              pc_q    <= pc_q;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          endcase
        end
        S_EXEC: begin
          if (beat && last) begin
            valid_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERROR: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign imem_addr   = pc_q;
  assign pe_valid    = valid_q;
  assign pe_last     = last;
  assign pe_lane_en  = mask_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed bench for accel_sequencer: sync ROM model, expected-beat queue
// drained by a negedge monitor, and per-run end-of-program checks.
module tb_accel_sequencer;
  import accel_pkg::*;

  localparam int PW = 6;
  localparam int AW = 8;
  localparam int NL = 4;
  localparam int W  = AW + 1 + NL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [PW-1:0] imem_addr;
  logic [15:0]   instruction = 16'h0000;
  logic          pe_valid;
  logic          pe_ready = 1'b1;
  logic [AW-1:0] pe_addr;
  logic          pe_last;
  logic [NL-1:0] pe_lane_en;
  seq_state_t    dbg_state;

  logic [15:0]   rom [64];
  logic [W-1:0]  exp_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            beats = 0;
  int            vcyc = 0;
  bit            stall_en = 1'b0;

  accel_sequencer #(.PC_WIDTH(PW), .ADDR_WIDTH(AW), .NUM_LANES(NL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .imem_addr  (imem_addr),
    .instruction(instruction),
    .pe_valid   (pe_valid),
    .pe_ready   (pe_ready),
    .pe_addr    (pe_addr),
    .pe_last    (pe_last),
    .pe_lane_en (pe_lane_en),
    .dbg_state_o(dbg_state)
  );

  // Clock and synchronous ROM
  always #5 clk = ~clk;
  always @(posedge clk) instruction <= rom[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bt(input logic [AW-1:0] a, input logic l, input logic [NL-1:0] m);
    return {a, l, m};
  endfunction

  // Monitor: drives pe_ready for the current cycle, then checks the beat.
  always @(negedge clk) begin
    if (rst_n && pe_valid) begin
      vcyc++;
      pe_ready = !(stall_en && (vcyc == 2 || vcyc == 3));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: got addr 0x%0h last %0b, expected no beat", pe_addr, pe_last);
      end else if (pe_ready) begin
        check("beat", 32'({pe_addr, pe_last, pe_lane_en}), 32'(exp_q.pop_front()));
        beats++;
      end else begin
        check("stall_hold", 32'({pe_addr, pe_last, pe_lane_en}), 32'(exp_q[0]));
      end
    end else begin
      pe_ready = 1'b1;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'hF000;
  endtask

  task automatic start_run();
    @(negedge clk);
    vcyc  = 0;
    beats = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(1));
    check("error_cleared", 32'(error), 32'(0));
    check("fetch_pc0", 32'(imem_addr), 32'(0));
  endtask

  task automatic wait_end(input bit exp_err, input int exp_beats);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (done || error) got = 1'b1;
    end
    check("end_reached", 32'(got), 32'(1));
    if (got) begin
      check("done_flag", 32'(done), 32'(!exp_err));
      check("error_flag", 32'(error), 32'(exp_err));
      check("busy_at_end", 32'(busy), 32'(0));
      check("valid_at_end", 32'(pe_valid), 32'(0));
      @(negedge clk);
      check("done_one_pulse", 32'(done), 32'(0));
      check("busy_low_after", 32'(busy), 32'(0));
      check("error_sticky", 32'(error), 32'(exp_err));
    end
    check("beat_count", 32'(beats), 32'(exp_beats));
    check("beats_left", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_error"}, 32'(error), 32'(0));
    check({tag, "_valid"}, 32'(pe_valid), 32'(0));
    check({tag, "_last"}, 32'(pe_last), 32'(0));
    check({tag, "_addr"}, 32'(pe_addr), 32'(0));
    check({tag, "_lane"}, 32'(pe_lane_en), 32'(4'hF));
    check({tag, "_pc"}, 32'(imem_addr), 32'(0));
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    bit found;
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: base 0x10, four beats
    clear_rom();
    rom[0] = 16'h1010; rom[1] = 16'h3004; rom[2] = 16'hF000;
    for (int i = 0; i < 4; i++) exp_q.push_back(bt(8'h10 + 8'(i), i == 3, 4'hF));
    start_run();
    wait_end(1'b0, 4);

    // 2: address wrap
    clear_rom();
    rom[0] = 16'h10FE; rom[1] = 16'h3003; rom[2] = 16'hF000;
    exp_q.push_back(bt(8'hFE, 1'b0, 4'hF));
    exp_q.push_back(bt(8'hFF, 1'b0, 4'hF));
    exp_q.push_back(bt(8'h00, 1'b1, 4'hF));
    start_run();
    wait_end(1'b0, 3);

    // 3: backpressure on second beat, new lane mask
    clear_rom();
    rom[0] = 16'h2005; rom[1] = 16'h1000; rom[2] = 16'h3003; rom[3] = 16'hF000;
    exp_q.push_back(bt(8'h00, 1'b0, 4'h5));
    exp_q.push_back(bt(8'h01, 1'b0, 4'h5));
    exp_q.push_back(bt(8'h02, 1'b1, 4'h5));
    stall_en = 1'b1;
    start_run();
    wait_end(1'b0, 3);
    stall_en = 1'b0;

    // 4a: LOOP 3 -> three groups of two
    clear_rom();
    rom[0] = 16'h1020; rom[1] = 16'h4003; rom[2] = 16'h3002; rom[3] = 16'h5000; rom[4] = 16'hF000;
    for (int g = 0; g < 3; g++) begin
      exp_q.push_back(bt(8'h20, 1'b0, 4'h5));
      exp_q.push_back(bt(8'h21, 1'b1, 4'h5));
    end
    start_run();
    wait_end(1'b0, 6);

    // 4b: LOOP 0 -> single pass
    clear_rom();
    rom[0] = 16'h4000; rom[1] = 16'h3002; rom[2] = 16'h5000; rom[3] = 16'hF000;
    exp_q.push_back(bt(8'h20, 1'b0, 4'h5));
    exp_q.push_back(bt(8'h21, 1'b1, 4'h5));
    start_run();
    wait_end(1'b0, 2);

    // 4c: stray ENDLOOP, CALC 0, CALC 1
    clear_rom();
    rom[0] = 16'h5000; rom[1] = 16'h3000; rom[2] = 16'h3001; rom[3] = 16'hF000;
    exp_q.push_back(bt(8'h20, 1'b1, 4'h5));
    start_run();
    wait_end(1'b0, 1);

    // 5: illegal opcode at pc=2, then restart from pc=0
    clear_rom();
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h7000; rom[3] = 16'h3004;
    start_run();
    wait_end(1'b1, 0);
    clear_rom();
    rom[0] = 16'h3001; rom[1] = 16'hF000; rom[3] = 16'h3004;
    exp_q.push_back(bt(8'h20, 1'b1, 4'h5));
    start_run();
    wait_end(1'b0, 1);

    // 6: reset during second beat of CALC 8
    clear_rom();
    rom[0] = 16'h1040; rom[1] = 16'h3008; rom[2] = 16'hF000;
    exp_q.push_back(bt(8'h40, 1'b0, 4'h5));
    start_run();
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk);
      #2;
      if (pe_valid && pe_addr == 8'h41) found = 1'b1;
    end
    check("second_beat_seen", 32'(found), 32'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    check("abort_beats", 32'(beats), 32'(1));
    check("abort_left", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    clear_rom();
    rom[0] = 16'h3002; rom[1] = 16'hF000;
    exp_q.push_back(bt(8'h00, 1'b0, 4'hF));
    exp_q.push_back(bt(8'h01, 1'b1, 4'hF));
    start_run();
    wait_end(1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
